// File: rtl/input_conditioner_if.sv
// rtl/input_conditioner_if.sv - board-side button/switch inputs and conditioned CPU-side outputs
interface input_conditioner_if;
   logic       ready_btn;
   logic [7:0] sw_in;
   logic       ready_out;
   logic [7:0] data_out;
   logic       busy;
`ifdef INPUT_COND_PRESS_COUNT_EN
   logic [7:0] press_count;

   modport master (output ready_btn, sw_in, input ready_out, data_out, busy, press_count);
   modport slave  (input ready_btn, sw_in, output ready_out, data_out, busy, press_count);
`else
   modport master (output ready_btn, sw_in, input ready_out, data_out, busy);
   modport slave  (input ready_btn, sw_in, output ready_out, data_out, busy);
`endif
endinterface

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronise + debounce ReadyIn, capture switches, stretch ready pulse
// Optional press counter output enabled by INPUT_COND_PRESS_COUNT_EN.
module input_conditioner #(
   parameter int SYNC_STAGES   = 2,
   parameter int DEBOUNCE_BITS = 20,
   parameter int HOLD_BITS     = 26
) (
   input logic                fastclk,
   input logic                n_reset,
   input_conditioner_if.slave io
);

   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_WAIT_RELEASE} state_t;

   logic [SYNC_STAGES-1:0]      r_btn_sync;
   logic [SYNC_STAGES-1:0][7:0] r_sw_sync;
   logic [DEBOUNCE_BITS-1:0]    r_db_cnt;
   logic                        r_btn_db;
   logic                        r_btn_db_d;
   logic [HOLD_BITS-1:0]        r_hold_cnt;
   state_t                      r_state;
   logic                        r_busy;
   logic                        r_ready_out;
   logic [7:0]                  r_data_out;
   logic                        w_btn_s;
   logic [7:0]                  w_sw_s;
   logic                        w_press;

   assign w_btn_s = r_btn_sync[SYNC_STAGES-1];
   assign w_sw_s  = r_sw_sync[SYNC_STAGES-1];
   assign w_press = r_btn_db & ~r_btn_db_d;

   always_ff @(posedge fastclk or negedge n_reset) begin
      if (!n_reset) begin
         r_btn_sync <= '0;
         r_sw_sync  <= '0;
      end else begin
         r_btn_sync <= {r_btn_sync[SYNC_STAGES-2:0], io.ready_btn};
         r_sw_sync  <= {r_sw_sync[SYNC_STAGES-2:0], io.sw_in};
      end
   end

   // Any return to the debounced level before the count saturates restarts it.
   always_ff @(posedge fastclk or negedge n_reset) begin
      if (!n_reset) begin
         r_db_cnt   <= '0;
         r_btn_db   <= 1'b0;
         r_btn_db_d <= 1'b0;
      end else begin
         r_btn_db_d <= r_btn_db;
         if (w_btn_s == r_btn_db) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == '1) begin
            r_btn_db <= w_btn_s;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};
         end
      end
   end

   always_ff @(posedge fastclk or negedge n_reset) begin
      if (!n_reset) begin
         r_state     <= S_IDLE;
         r_busy      <= 1'b0;
         r_ready_out <= 1'b0;
         r_data_out  <= 8'h00;
         r_hold_cnt  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_press) begin
                  r_data_out  <= w_sw_s;
                  r_ready_out <= 1'b1;
                  r_hold_cnt  <= '0;
                  r_state     <= S_HOLD;
                  r_busy      <= 1'b1;
               end
            end
            S_HOLD: begin
               if (r_hold_cnt == '1) begin
                  r_ready_out <= 1'b0;
                  r_hold_cnt  <= '0;
                  if (r_btn_db) begin
                     r_state <= S_WAIT_RELEASE;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_hold_cnt <= r_hold_cnt + {{(HOLD_BITS-1){1'b0}}, 1'b1};
               end
            end
            S_WAIT_RELEASE: begin
               if (!r_btn_db) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_busy      <= 1'b0;
               r_ready_out <= 1'b0;
            end
         endcase
      end
   end

   assign io.ready_out = r_ready_out;
   assign io.data_out  = r_data_out;
   assign io.busy      = r_busy;

`ifdef INPUT_COND_PRESS_COUNT_EN
   logic [7:0] r_press_count;

   always_ff @(posedge fastclk or negedge n_reset) begin
      if (!n_reset) begin
         r_press_count <= 8'h00;
      end else if (r_state == S_IDLE && w_press) begin
         r_press_count <= r_press_count + 8'd1;
      end
   end

   assign io.press_count = r_press_count;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner (SYNC=2, DB=3, HOLD=4)
module tb_input_conditioner;

   logic fastclk;
   logic n_reset;
   int   total = 0;
   int   bad   = 0;

   input_conditioner_if ifc();

   input_conditioner #(
      .SYNC_STAGES  (2),
      .DEBOUNCE_BITS(3),
      .HOLD_BITS    (4)
   ) dut (
      .fastclk(fastclk),
      .n_reset(n_reset),
      .io     (ifc)
   );

   initial fastclk = 1'b0;
   always #5 fastclk = ~fastclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Press with switches set; returns edges to ready_out rise (1 = sampling edge) and pulse width.
   task automatic press_pulse(input logic [7:0] sw, output int lat, output int width);
      @(negedge fastclk);
      ifc.sw_in     = sw;
      ifc.ready_btn = 1'b1;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge fastclk); #1;
         if (ifc.ready_out) begin
            lat = k;
            break;
         end
      end
      width = 0;
      if (lat != 0) begin
         width = 1;
         for (int k = 0; k < 100; k++) begin
            @(posedge fastclk); #1;
            if (!ifc.ready_out) break;
            width++;
         end
      end
   endtask

   task automatic release_wait(input string tag);
      int n;
      n = 0;
      @(negedge fastclk);
      ifc.ready_btn = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge fastclk); #1;
         if (!ifc.busy) begin
            n = k;
            break;
         end
      end
      chk(tag, n, 11);
   endtask

   initial begin
      int lat, width, hi_cnt, rise_n, bad_data;
      logic [7:0] data_at_rise;

      n_reset       = 1'b0;
      ifc.ready_btn = 1'b0;
      ifc.sw_in     = 8'h00;
      #1;
      chk("rst_ready", ifc.ready_out, 0);
      chk("rst_data", ifc.data_out, 8'h00);
      chk("rst_busy", ifc.busy, 0);
      repeat (3) @(posedge fastclk);
      @(negedge fastclk);
      n_reset = 1'b1;

      for (int k = 0; k < 50; k++) begin
         @(posedge fastclk); #1;
         chk("idle_ready", ifc.ready_out, 0);
         chk("idle_data", ifc.data_out, 8'h00);
         chk("idle_busy", ifc.busy, 0);
      end

      // Clean press, held past the pulse
      press_pulse(8'hA5, lat, width);
      chk("press_latency", lat, 11);
      chk("press_width", width, 16);
      chk("press_data", ifc.data_out, 8'hA5);
      chk("press_busy_held", ifc.busy, 1);
      repeat (5) @(posedge fastclk);
      #1;
      chk("wait_release_busy", ifc.busy, 1);
      chk("wait_release_ready", ifc.ready_out, 0);
      release_wait("release_latency");

      // Bouncing button never accepted
      for (int n = 0; n < 40; n++) begin
         @(negedge fastclk);
         ifc.ready_btn = ((n / 3) % 2 == 0);
         @(posedge fastclk); #1;
         chk("bounce_ready", ifc.ready_out, 0);
         chk("bounce_busy", ifc.busy, 0);
         chk("bounce_db", dut.r_btn_db, 0);
      end
      @(negedge fastclk);
      ifc.ready_btn = 1'b0;
      repeat (20) @(posedge fastclk);
      #1;
      chk("bounce_after_db", dut.r_btn_db, 0);
      chk("bounce_after_data", ifc.data_out, 8'hA5);

      // Switch change and re-press during HOLD
      @(negedge fastclk);
      ifc.sw_in     = 8'hA5;
      ifc.ready_btn = 1'b1;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge fastclk); #1;
         if (ifc.ready_out) begin
            lat = k;
            break;
         end
      end
      chk("hold_press_latency", lat, 11);
      hi_cnt = 0; rise_n = 0; bad_data = 0; data_at_rise = 8'h00;
      for (int n = 1; n <= 45; n++) begin
         @(negedge fastclk);
         if (n == 2) begin
            ifc.sw_in     = 8'h3C;
            ifc.ready_btn = 1'b0;
         end
         if (n == 12) ifc.ready_btn = 1'b1;
         @(posedge fastclk); #1;
         if (n < 22 && ifc.data_out !== 8'hA5) bad_data++;
         if (n <= 16 && ifc.ready_out) hi_cnt++;
         if (n > 16 && rise_n == 0 && ifc.ready_out) begin
            rise_n       = n;
            data_at_rise = ifc.data_out;
         end
      end
      chk("hold_first_width", 1 + hi_cnt, 16);
      chk("hold_data_stable", bad_data, 0);
      chk("hold_second_rise", rise_n, 22);
      chk("hold_second_data", data_at_rise, 8'h3C);
      release_wait("hold_release_latency");

      // Asynchronous reset mid-HOLD
      @(negedge fastclk);
      ifc.sw_in     = 8'hC3;
      ifc.ready_btn = 1'b1;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge fastclk); #1;
         if (ifc.ready_out) begin
            lat = k;
            break;
         end
      end
      chk("arst_press_latency", lat, 11);
      repeat (5) @(posedge fastclk);
      #3;
      n_reset = 1'b0;
      #1;
      chk("arst_ready", ifc.ready_out, 0);
      chk("arst_busy", ifc.busy, 0);
      chk("arst_data", ifc.data_out, 8'h00);
      @(negedge fastclk);
      ifc.ready_btn = 1'b0;
      @(negedge fastclk);
      n_reset = 1'b1;
      repeat (2) @(posedge fastclk);
      press_pulse(8'h5A, lat, width);
      chk("arst_after_latency", lat, 11);
      chk("arst_after_width", width, 16);
      chk("arst_after_data", ifc.data_out, 8'h5A);
      release_wait("arst_after_release");

`ifdef INPUT_COND_PRESS_COUNT_EN
      @(negedge fastclk);
      n_reset = 1'b0;
      @(negedge fastclk);
      n_reset = 1'b1;
      #1;
      chk("count_reset", ifc.press_count, 8'd0);
      for (int p = 0; p < 257; p++) begin
         press_pulse(p[7:0], lat, width);
         release_wait("count_release");
         if (p == 9) chk("count_ten", ifc.press_count, 8'd10);
      end
      chk("count_wrap", ifc.press_count, 8'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Board-input front end that sits directly upstream of the CPU's `ready_in` / `in_port`.
- Runs on the 50 MHz `fastclk` domain.
- Synchronises the raw ReadyIn pushbutton and the 8 switches, then debounces the button.
- On each accepted press it captures the switch byte and holds `ready_out` high long enough for the divided-clock CPU to sample it.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchroniser on the button and each switch bit (minimum 2).
- DEBOUNCE_BITS, 20, debounce counter width; the button must differ from its debounced state for 2^DEBOUNCE_BITS consecutive cycles before the change is accepted.
- HOLD_BITS, 26, hold counter width; `ready_out` stays high for exactly 2^HOLD_BITS cycles, which is at least one divided-clock period.

Ports:
- fastclk  input  1  free-running board clock; all logic is on its rising edge.
- n_reset  input  1  reset; asynchronous assertion, active-low.
- ready_btn  input  1  raw ReadyIn pushbutton, asynchronous, bouncy, active-high.
- sw_in  input  8  raw switches, asynchronous.
- ready_out  output  1  conditioned ready to the CPU `ready_in`.
- data_out  output  8  switch byte captured at press acceptance, to the CPU `in_port`.
- busy  output  1  high while in HOLD or WAIT_RELEASE.

Behaviour:
- Reset, asynchronous while `n_reset` is 0:
  - All synchroniser flops, the debounced button `btn_db`, and both counters go to 0.
  - `ready_out` = 0, `data_out` = 8'h00, `busy` = 0, state = IDLE.
  - Asserting reset mid-HOLD drops `ready_out` immediately, without waiting for a clock.
- Synchroniser:
  - The button and each switch bit pass through their own SYNC_STAGES flop chain; the outputs are `btn_s` and `sw_s`.
  - Switches are not debounced.
- Debounce:
  - When `btn_s` == `btn_db`, `db_cnt` is cleared to 0.
  - Otherwise `db_cnt` increments by 1 each cycle.
  - On the cycle `db_cnt` == 2^DEBOUNCE_BITS-1 and `btn_s` != `btn_db`: `btn_db` <= `btn_s` and `db_cnt` <= 0.
  - Any bounce back to `btn_db` before that point restarts the count from 0.
- FSM, registered, states IDLE, HOLD and WAIT_RELEASE:
  - IDLE:
    - On the cycle `btn_db` is 1 and was 0 the previous cycle (registered rising edge): `data_out` <= `sw_s`, `ready_out` <= 1, `hold_cnt` <= 0, go to HOLD.
  - HOLD:
    - `hold_cnt` increments each cycle.
    - When `hold_cnt` == 2^HOLD_BITS-1: `ready_out` <= 0, then go to WAIT_RELEASE if `btn_db` = 1, else to IDLE.
    - Press edges arriving during HOLD are ignored and are not queued.
  - WAIT_RELEASE:
    - Go to IDLE on the first cycle `btn_db` = 0.
    - A new press requires a release followed by a fresh debounced rising edge.
- `busy` = (state != IDLE), registered together with the state.
- `data_out` changes only on press acceptance and holds its value indefinitely otherwise.
- `ready_out` pulse width is exactly 2^HOLD_BITS cycles.
- Latency from the first cycle the raw button is sampled high and then held stable to `ready_out` rising:
  - SYNC_STAGES + 2^DEBOUNCE_BITS + 1 cycles.
  - This comprises the synchroniser, the debounce count and the FSM register.
- Counters never wrap:
  - `db_cnt` is bounded by the compare-and-clear.
  - `hold_cnt` is cleared on entry to HOLD.

Optional Feature:
- Macro INPUT_COND_PRESS_COUNT_EN.
- When defined:
  - Adds output `press_count` [7:0], reset to 0.
  - It increments by 1 on every accepted press, i.e. each IDLE->HOLD transition, and wraps from 255 to 0.
  - Ignored edges in HOLD and bounces do not count.
- When undefined:
  - The port and its counter are absent.
  - All other behaviour is identical.

Test Plan (all scenarios run with DEBOUNCE_BITS=3, HOLD_BITS=4, SYNC_STAGES=2):
- Reset release, inputs idle -> `ready_out`=0, `data_out`=8'h00, `busy`=0 for 50 cycles.
- `sw_in`=8'hA5, button held high -> `ready_out` rises exactly 2+8+1=11 cycles after the first high sample; `data_out`=8'hA5 on the same cycle; `ready_out` high for exactly 16 cycles; `busy` stays 1 until release.
- Button toggled every 3 cycles for 40 cycles, then released -> `ready_out` never asserts; `btn_db` stays 0.
- Press accepted, `sw_in` changed to 8'h3C during HOLD, button released and pressed again within HOLD -> `data_out` stays 8'hA5; exactly one 16-cycle pulse; the second press is accepted only after returning to IDLE.
- `n_reset` asserted 5 cycles into HOLD -> `ready_out`, `busy` and `data_out` go to 0 before the next clock edge; after release, a stable press produces a normal pulse.
- With INPUT_COND_PRESS_COUNT_EN: 257 clean presses -> `press_count`=1; without the macro the design compiles with the port absent.
